// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache between CPU and Main_Memory.
// Latency: read hit 2 cycles; read miss / write 2 cycles + memory latency (3 minimum).
// Backpressure: requests taken only in IDLE (busy low); memory stalls via mem_Done.
module cache_controller #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 13,
    parameter int INDEX_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              read,
    input  logic              write,
    input  logic              instruction,
    input  logic              flush,
    output logic [DATA_W-1:0] dataOut,
    output logic              Done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_instruction,
    input  logic [DATA_W-1:0] mem_dataOut,
    input  logic              mem_Done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    // Tag carries the instruction bit so I- and D-space never alias.
    localparam int TAG_W = ADDR_W - INDEX_W + 1;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE_MEM, RESPOND} state_t;

    state_t              state_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   line_q [LINES];

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                instr_q;
    logic                wr_q;

    logic [DATA_W-1:0]   data_out_q;
    logic                done_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_dat_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic                mem_ins_q;
    logic [CNT_W-1:0]    hit_cnt_q;
    logic [CNT_W-1:0]    hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q;
    logic [CNT_W-1:0]    miss_cnt_d;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic                fill_load;
    logic                wr_update;

    assign idx       = addr_q[INDEX_W-1:0];
    assign req_tag   = {instr_q, addr_q[ADDR_W-1:INDEX_W]};
    assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
    assign fill_load = (state_q == FILL) && mem_Done;
    assign wr_update = (state_q == LOOKUP) && wr_q && hit;

    assign hit_cnt_d  = (hit_cnt_q  == {CNT_W{1'b1}}) ? hit_cnt_q  : hit_cnt_q  + CNT_W'(1);
    assign miss_cnt_d = (miss_cnt_q == {CNT_W{1'b1}}) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);

    assign dataOut         = data_out_q;
    assign Done            = done_q;
    assign busy            = (state_q != IDLE);
    assign mem_address     = mem_addr_q;
    assign mem_dataIn      = mem_dat_q;
    assign mem_read        = mem_rd_q;
    assign mem_write       = mem_wr_q;
    assign mem_instruction = mem_ins_q;
    assign hit_count       = hit_cnt_q;
    assign miss_count      = miss_cnt_q;

    // Line payload (tag/data); meaningless while invalid, so no reset needed.
    always_ff @(posedge clk) begin
        if (fill_load) begin
            tag_q[idx]  <= req_tag;
            line_q[idx] <= mem_dataOut;
        end else if (wr_update) begin
            line_q[idx] <= wdata_q;
        end
    end

    // Controller FSM with registered CPU/memory outputs, valid bits and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            instr_q    <= 1'b0;
            wr_q       <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_dat_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_ins_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (write || read) begin
                        addr_q  <= address;
                        wdata_q <= dataIn;
                        instr_q <= instruction;
                        wr_q    <= write;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (wr_q) begin
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= addr_q;
                        mem_dat_q  <= wdata_q;
                        mem_ins_q  <= instr_q;
                        state_q    <= WRITE_MEM;
                    end else if (hit) begin
                        data_out_q <= line_q[idx];
                        hit_cnt_q  <= hit_cnt_d;
                        done_q     <= 1'b1;
                        state_q    <= RESPOND;
                    end else begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= addr_q;
                        mem_ins_q  <= instr_q;
                        miss_cnt_q <= miss_cnt_d;
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_Done) begin
                        valid_q[idx] <= 1'b1;
                        data_out_q   <= mem_dataOut;
                        mem_rd_q     <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= RESPOND;
                    end
                end
                WRITE_MEM: begin
                    if (mem_Done) begin
                        mem_wr_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= RESPOND;
                    end
                end
                RESPOND: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller (CNT_W=4 so saturation is reachable).
// Bench plays the CPU and a memory with a per-transaction latency.
// Outputs sampled 1 time unit after each rising edge.
module tb_cache_controller;
    logic        clk;
    logic        reset;
    logic [12:0] address;
    logic [12:0] dataIn;
    logic        read;
    logic        write;
    logic        instruction;
    logic        flush;
    logic [12:0] dataOut;
    logic        Done;
    logic        busy;
    logic [12:0] mem_address;
    logic [12:0] mem_dataIn;
    logic        mem_read;
    logic        mem_write;
    logic        mem_instruction;
    logic [12:0] mem_dataOut;
    logic        mem_Done;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;

    int n_assert = 0;
    int n_fail   = 0;

    cache_controller #(.ADDR_W(13), .DATA_W(13), .INDEX_W(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .address(address), .dataIn(dataIn),
        .read(read), .write(write), .instruction(instruction), .flush(flush),
        .dataOut(dataOut), .Done(Done), .busy(busy),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn),
        .mem_read(mem_read), .mem_write(mem_write), .mem_instruction(mem_instruction),
        .mem_dataOut(mem_dataOut), .mem_Done(mem_Done),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One CPU transaction; memory raises mem_Done after 'lat' strobe cycles.
    task automatic xact(input string tag, input logic wr, input logic rd, input logic ins,
                        input logic [12:0] addr, input logic [12:0] wdat, input int lat,
                        input logic [12:0] mdat, input logic fl,
                        input int exp_cyc, input int exp_rd, input int exp_wr);
        int cyc;
        int nrd;
        int nwr;
        bit seen;
        cyc = 0; nrd = 0; nwr = 0; seen = 0;
        write = wr; read = rd; instruction = ins; address = addr; dataIn = wdat;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (Done === 1'b1) begin
                seen = 1;
                read = 1'b0; write = 1'b0; mem_Done = 1'b0; flush = 1'b0;
            end else if (mem_read === 1'b1 || mem_write === 1'b1) begin
                if (mem_read === 1'b1) nrd++;
                if (mem_write === 1'b1) nwr++;
                if (nrd + nwr == 1) begin
                    chk({tag, "_mem_addr"}, mem_address, addr);
                    chk({tag, "_mem_instr"}, mem_instruction, ins);
                    if (wr) chk({tag, "_mem_wdata"}, mem_dataIn, wdat);
                end
                flush = fl;
                if (nrd + nwr == lat) begin
                    mem_Done = 1'b1;
                    mem_dataOut = mdat;
                end
            end
        end
        read = 1'b0; write = 1'b0; mem_Done = 1'b0; flush = 1'b0;
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_rd_strobes"}, nrd, exp_rd);
        chk({tag, "_wr_strobes"}, nwr, exp_wr);
        chk({tag, "_strobe_low"}, {mem_read, mem_write}, 2'b00);
        tick();
        chk({tag, "_done_pulse"}, {Done, busy}, 2'b00);
    endtask

    initial begin
        reset = 1'b1; address = '0; dataIn = '0; read = 1'b0; write = 1'b0;
        instruction = 1'b0; flush = 1'b0; mem_dataOut = '0; mem_Done = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_done", Done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {mem_read, mem_write, mem_instruction}, 3'b000);
        chk("rst_mem_addr", mem_address, 13'h0);
        chk("rst_mem_wdata", mem_dataIn, 13'h0);
        chk("rst_dataout", dataOut, 13'h0);
        chk("rst_counts", {hit_count, miss_count}, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Cold data miss, then hit on the same address.
        xact("rd5_miss", 0, 1, 0, 13'h0005, 13'h0, 3, 13'h0ABC, 0, 5, 3, 0);
        chk("rd5_miss_data", dataOut, 13'h0ABC);
        chk("rd5_miss_cnt", {hit_count, miss_count}, {4'd0, 4'd1});
        xact("rd5_hit", 0, 1, 0, 13'h0005, 13'h0, 0, 13'h0, 0, 2, 0, 0);
        chk("rd5_hit_data", dataOut, 13'h0ABC);
        chk("rd5_hit_cnt", {hit_count, miss_count}, {4'd1, 4'd1});

        // Instruction space is a separate namespace; minimum miss latency.
        xact("ird5", 0, 1, 1, 13'h0005, 13'h0, 1, 13'h0111, 0, 3, 1, 0);
        chk("ird5_data", dataOut, 13'h0111);
        chk("ird5_cnt", miss_count, 4'd2);

        // Conflicting tag at index 5 evicts.
        xact("rdD_miss", 0, 1, 0, 13'h000D, 13'h0, 2, 13'h0222, 0, 4, 2, 0);
        chk("rdD_miss_data", dataOut, 13'h0222);
        xact("rdD_hit", 0, 1, 0, 13'h000D, 13'h0, 0, 13'h0, 0, 2, 0, 0);
        chk("rdD_hit_data", dataOut, 13'h0222);
        chk("rdD_cnt", {hit_count, miss_count}, {4'd2, 4'd3});
        xact("rd5_refill", 0, 1, 0, 13'h0005, 13'h0, 1, 13'h0ABC, 0, 3, 1, 0);
        chk("rd5_refill_cnt", miss_count, 4'd4);

        // Write hit updates the line; counters and dataOut untouched.
        xact("wr5", 1, 0, 0, 13'h0005, 13'h1F0F, 2, 13'h0, 0, 4, 0, 2);
        chk("wr5_dataout_held", dataOut, 13'h0ABC);
        chk("wr5_cnt", {hit_count, miss_count}, {4'd2, 4'd4});
        xact("rd5_after_wr", 0, 1, 0, 13'h0005, 13'h0, 0, 13'h0, 0, 2, 0, 0);
        chk("rd5_after_wr_data", dataOut, 13'h1F0F);
        chk("rd5_after_wr_cnt", hit_count, 4'd3);

        // Write miss does not allocate.
        xact("wr7", 1, 0, 0, 13'h0007, 13'h0777, 1, 13'h0, 0, 3, 0, 1);
        xact("rd7", 0, 1, 0, 13'h0007, 13'h0, 1, 13'h0777, 0, 3, 1, 0);
        chk("rd7_data", dataOut, 13'h0777);
        chk("rd7_cnt", miss_count, 4'd5);

        // Flush in IDLE: no Done, lines invalid, counters kept.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {Done, busy}, 2'b00);
        xact("rd5_flushed", 0, 1, 0, 13'h0005, 13'h0, 1, 13'h1F0F, 0, 3, 1, 0);
        chk("rd5_flushed_cnt", {hit_count, miss_count}, {4'd3, 4'd6});

        // Flush during FILL is ignored.
        xact("rd3_flush_fill", 0, 1, 0, 13'h0003, 13'h0, 2, 13'h0333, 1, 4, 2, 0);
        xact("rd3_hit", 0, 1, 0, 13'h0003, 13'h0, 0, 13'h0, 0, 2, 0, 0);
        chk("rd3_hit_data", dataOut, 13'h0333);
        xact("rd5_kept", 0, 1, 0, 13'h0005, 13'h0, 0, 13'h0, 0, 2, 0, 0);
        chk("rd5_kept_data", dataOut, 13'h1F0F);
        chk("flush_fill_cnt", {hit_count, miss_count}, {4'd5, 4'd7});

        // read and write together: write wins.
        xact("rdwr3", 1, 1, 0, 13'h0003, 13'h0444, 1, 13'h0, 0, 3, 0, 1);
        xact("rd3_new", 0, 1, 0, 13'h0003, 13'h0, 0, 13'h0, 0, 2, 0, 0);
        chk("rd3_new_data", dataOut, 13'h0444);
        chk("rdwr_cnt", {hit_count, miss_count}, {4'd6, 4'd7});

        // Stray mem_Done in IDLE.
        mem_Done = 1'b1;
        tick();
        tick();
        mem_Done = 1'b0;
        chk("stray_done", {Done, busy, mem_read, mem_write}, 4'b0000);
        xact("rd3_after_stray", 0, 1, 0, 13'h0003, 13'h0, 0, 13'h0, 0, 2, 0, 0);
        chk("stray_cnt", hit_count, 4'd7);

        // Miss counter saturates at 15.
        for (int k = 1; k <= 10; k++) begin
            xact("sat_rd", 0, 1, 0, 13'(k * 8), 13'h0, 1, 13'(k), 0, 3, 1, 0);
            chk("sat_miss_cnt", miss_count, (7 + k > 15) ? 4'd15 : 4'(7 + k));
        end
        chk("sat_hit_cnt", hit_count, 4'd7);

        // Reset in the middle of a fill.
        address = 13'h0006; instruction = 1'b0; read = 1'b1;
        tick();
        tick();
        chk("mid_fill_state", {busy, mem_read}, 2'b11);
        #2;
        reset = 1'b0;
        mem_Done = 1'b1;
        mem_dataOut = 13'h0666;
        #1;
        chk("mid_rst_async", {mem_read, Done, busy}, 3'b000);
        chk("mid_rst_cnt", {hit_count, miss_count}, 8'h00);
        read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_Done = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", {Done, busy}, 2'b00);
        chk("post_rst_dataout", dataOut, 13'h0);
        xact("rd6_after_rst", 0, 1, 0, 13'h0006, 13'h0, 1, 13'h0666, 0, 3, 1, 0);
        chk("rd6_after_rst_cnt", {hit_count, miss_count}, {4'd0, 4'd1});
        chk("rd6_after_rst_data", dataOut, 13'h0666);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
# cache_controller

Parametrised direct-mapped, write-through, no-write-allocate cache between the CPU datapath and the `Main_Memory` block. It presents the same read/write/instruction/Done request interface as `Main_Memory` on the CPU side and drives an identical interface toward memory. Unlike the uncached path, it serves read hits without a memory access, keeps instruction and data in separate tag namespaces, supports a one-cycle flush, and exposes saturating hit/miss counters.

## Interface
- `ADDR_W`, 13, address width, CPU and memory side
- `DATA_W`, 13, data word width
- `INDEX_W`, 3, index bits; lines = 2^INDEX_W, one word per line
- `CNT_W`, 16, width of each statistics counter
- `clk`  in  1  clock, all state changes on rising edge
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately
- `address`  in  ADDR_W  CPU request address
- `dataIn`  in  DATA_W  CPU write data
- `read` / `write`  in  1  CPU request levels; write wins if both high
- `instruction`  in  1  1 = instruction space, 0 = data space
- `flush`  in  1  invalidate all lines
- `dataOut`  out  DATA_W  read result, registered
- `Done`  out  1  one-cycle completion pulse
- `busy`  out  1  high whenever state is not IDLE
- `mem_address`  out  ADDR_W, `mem_dataIn`  out  DATA_W, `mem_read` / `mem_write` / `mem_instruction`  out  1  memory request, registered
- `mem_dataOut`  in  DATA_W, `mem_Done`  in  1  memory response
- `hit_count` / `miss_count`  out  CNT_W  saturating statistics

## Operation
- Index = `address[INDEX_W-1:0]`; tag = {`instruction`, `address[ADDR_W-1:INDEX_W]`}, width ADDR_W-INDEX_W+1. Each line holds a valid bit, a tag and a data word.
- States: IDLE, LOOKUP, FILL, WRITE_MEM, RESPOND.
- IDLE: `flush` high → clear all valid bits, stay in IDLE, no Done. `flush` has priority over `read`/`write`. Otherwise `write` or `read` high → latch `address`, `dataIn`, `instruction` and the operation, go to LOOKUP.
- `flush` outside IDLE is ignored.
- Requests outside IDLE are ignored. The requester holds `read`/`write` until Done and drops them in the Done cycle.
- LOOKUP, read hit: `dataOut` ← line data, `hit_count`+1, go to RESPOND.
- LOOKUP, read miss: set `mem_read`=1, `mem_address`/`mem_instruction` ← latched values, `miss_count`+1, go to FILL.
- LOOKUP, write: if hit, update line data, otherwise leave the line untouched (no allocate). Set `mem_write`=1 and drive `mem_address`/`mem_dataIn`/`mem_instruction`. Go to WRITE_MEM. Writes do not change the counters.
- FILL: wait for `mem_Done`=1. Then load the line (valid=1, tag, `mem_dataOut`), set `dataOut` ← `mem_dataOut`, set `mem_read`=0, go to RESPOND.
- WRITE_MEM: wait for `mem_Done`=1. Then set `mem_write`=0 and go to RESPOND.
- `mem_Done` in IDLE, LOOKUP or RESPOND is ignored.
- RESPOND: `Done`=1 for exactly this cycle, then go to IDLE.
- Counters saturate at 2^CNT_W−1. `flush` does not clear them; only `reset` does.
- Reset values: state IDLE, all valid bits 0, counters 0, `dataOut` 0, and `Done`, `busy`, `mem_read`, `mem_write`, `mem_instruction`, `mem_address`, `mem_dataIn` all 0.
- Reset mid-transaction: the request is abandoned, `mem_read`/`mem_write` drop asynchronously, and no Done is issued. A line being filled is not validated.

## Timing
- Request sampled at edge E0 (state IDLE).
- Read hit: Done high during the cycle after E1; back in IDLE after E2. Fixed 2-cycle round trip, no memory traffic.
- Read miss or any write: `mem_read`/`mem_write` high from E1. If `mem_Done` is first sampled high at edge Em, the memory strobe falls and Done is high for the cycle after Em.
- Minimum miss round trip is 3 cycles, reached when `mem_Done` is already high at E2.
- `dataOut` holds its value until the next read completes.
- `busy` = (state ≠ IDLE), combinational from the state register.

## Test plan
- Reset, then read data address 0x0005 with `mem_dataOut`=0x0ABC and `mem_Done` after 3 cycles → one `mem_read` burst, Done once, `dataOut`=0x0ABC, `miss_count`=1. Repeat the read → Done 2 cycles after sampling, no `mem_read`, `hit_count`=1.
- Read 0x0005 with `instruction`=1 after the data fill above → miss (separate namespace), `miss_count`=2. Then read 0x000D (same index 5, different tag) → miss, evicting the line.
- Write 0x1F0F to cached 0x0005 → `mem_write` with `mem_dataIn`=0x1F0F, Done after `mem_Done`. Subsequent read is a hit returning 0x1F0F. Write to uncached 0x0007 followed by a read of 0x0007 → the read misses (no allocate).
- `flush` in IDLE, then read 0x0005 → miss. Assert `flush` while in FILL → ignored; the line is still valid afterwards.
- Drive `read`=`write`=1 together → write is performed. Pulse `mem_Done` while in IDLE → no state change. Set `miss_count` near saturation (CNT_W=4, 16 misses) → it holds at 15.
- Assert `reset` low mid-FILL → `mem_read`, `Done` and `busy` drop immediately, no Done follows, and the next read of that address misses.
